// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end for the soft RISC-V core.
// Drives the word address into a combinational instruction ROM, captures
// the returned word together with its PC in a 2-entry queue and offers the
// queue head to decode over a valid/ready handshake. Redirects flush the
// queue and restart fetch. A misaligned or out-of-range fetch PC produces a
// single fault entry, and fetch then stops until the next redirect.

module ifetch_unit #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] rom_address,
   input  logic [31:0]           rom_data,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_instr,
   output logic [31:0]           out_pc,
   output logic                  out_fault
);

   typedef enum logic {
      RUN     = 1'b0,
      STOPPED = 1'b1
   } fetch_state_t;

   fetch_state_t state;
   fetch_state_t state_next;

   logic [31:0] fetch_pc;
   logic        fetch_fault;
   logic        fetch_en;

   // Queue storage: two slots addressed by a read pointer plus occupancy.
   logic [31:0] q_pc    [2];
   logic [31:0] q_instr [2];
   logic        q_fault [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;

   logic pop;
   logic push;
   logic commit_push;
   logic commit_pop;

   // Fault when the PC is not word aligned or lies beyond the ROM window.
   always_comb begin
      fetch_fault = (fetch_pc[1:0] != 2'b00) ||
                    ((fetch_pc >> (ADDR_WIDTH + 2)) != 32'h0);
   end

   // ROM word address; held at the reset PC while reset is asserted.
   always_comb begin
      if (reset) begin
         rom_address = RESET_PC[ADDR_WIDTH+1:2];
      end else begin
         rom_address = fetch_pc[ADDR_WIDTH+1:2];
      end
   end

   // Fetch FSM state register.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its peers.
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Fetch FSM next state: redirect restarts, a pushed fault stops.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_next
      // unassigned and a latch cannot be inferred.
      state_next = state;
      if (redirect_valid) begin
         state_next = RUN;
      end else if (push && fetch_fault) begin
         state_next = STOPPED;
      end
   end

   // Fetch FSM outputs: fetching is enabled only in RUN.
   always_comb begin
      fetch_en = (state == RUN);
   end

   // Handshake and queue control; redirect and reset discard both sides.
   always_comb begin
      out_valid   = !reset && (count != 2'd0);
      pop         = out_valid && out_ready;
      push        = fetch_en && ((count < 2'd2) || pop);
      commit_push = push && !reset && !redirect_valid;
      commit_pop  = pop && !redirect_valid;
      // Tail slot: rd_ptr when empty or full, the other slot when half full.
      wr_ptr      = rd_ptr ^ count[0];
   end

   // Occupancy and read pointer; reset and redirect both empty the queue.
   always_ff @(posedge clock) begin
      if (reset || redirect_valid) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
      end else begin
         case ({commit_push, commit_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (commit_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Fetch PC: reset beats redirect, which beats sequential advance.
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
      end else if (commit_push && !fetch_fault) begin
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // Queue slot write on push; fault entries carry a zero instruction.
   always_ff @(posedge clock) begin
      // NOTE: the queue slots have no reset; count gates every read, so
      // stale slot contents are never visible.
      if (commit_push) begin
         q_pc[wr_ptr]    <= fetch_pc;
         q_instr[wr_ptr] <= fetch_fault ? 32'h0 : rom_data;
         q_fault[wr_ptr] <= fetch_fault;
      end
   end

   // Head outputs; all zero when the queue is empty or in reset.
   always_comb begin
      out_instr = 32'h0;
      out_pc    = 32'h0;
      out_fault = 1'b0;
      if (out_valid) begin
         out_instr = q_instr[rd_ptr];
         out_pc    = q_pc[rd_ptr];
         out_fault = q_fault[rd_ptr];
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed vector bench for ifetch_unit. The bench ROM
// returns 32'hA0000000 + rom_address. Each vector drives inputs at the
// falling edge and compares outputs 1 ns later, before the next rising edge.

module tb_ifetch_unit;

   localparam int AW = 10;

   logic          clock;
   logic          reset;
   logic [AW-1:0] rom_address;
   logic [31:0]   rom_data;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [31:0]   out_pc;
   logic          out_fault;

   int compared;
   int mismatched;

   ifetch_unit #(
      .ADDR_WIDTH (AW),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .rom_address    (rom_address),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_fault      (out_fault)
   );

   assign rom_data = 32'hA000_0000 + {22'h0, rom_address};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic          rst;
      logic          rdy;
      logic          rv;
      logic [31:0]   rpc;
      logic          ev;
      logic [31:0]   epc;
      logic [31:0]   ei;
      logic          ef;
      logic [AW-1:0] ea;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                      input logic ef, input logic [AW-1:0] ea);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.ev = ev; v.epc = epc; v.ei = ei; v.ef = ef; v.ea = ea;
      vecs.push_back(v);
   endtask

   localparam logic [31:0] I = 32'hA000_0000;

   initial begin
      logic found;
      compared   = 0;
      mismatched = 0;
      reset          = 1'b1;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      //   rst rdy rv rpc        | v  pc       instr    f  rom
      // Straight-line fetch
      add(1, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h0);   // 0 reset
      add(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h0);   // 1 first fetch
      add(0, 1, 0, 32'h0,       1, 32'h0,   I+0,     0, 10'h1);
      add(0, 1, 0, 32'h0,       1, 32'h4,   I+1,     0, 10'h2);
      add(0, 1, 0, 32'h0,       1, 32'h8,   I+2,     0, 10'h3);
      add(0, 1, 0, 32'h0,       1, 32'hC,   I+3,     0, 10'h4);
      // Backpressure from pc 0
      add(1, 0, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h0);   // 6 reset
      add(0, 0, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h0);
      add(0, 0, 0, 32'h0,       1, 32'h0,   I+0,     0, 10'h1);
      add(0, 0, 0, 32'h0,       1, 32'h0,   I+0,     0, 10'h2);   // full
      add(0, 0, 0, 32'h0,       1, 32'h0,   I+0,     0, 10'h2);
      add(0, 0, 0, 32'h0,       1, 32'h0,   I+0,     0, 10'h2);
      add(0, 1, 0, 32'h0,       1, 32'h0,   I+0,     0, 10'h2);   // release
      add(0, 1, 0, 32'h0,       1, 32'h4,   I+1,     0, 10'h3);
      add(0, 0, 0, 32'h0,       1, 32'h8,   I+2,     0, 10'h4);   // holds 8,12
      // Redirect to 0x100 while queue holds 8,12
      add(0, 0, 1, 32'h100,     1, 32'h8,   I+2,     0, 10'h4);
      add(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h40);
      add(0, 1, 0, 32'h0,       1, 32'h100, I+32'h40,0, 10'h41);
      // Misaligned redirect
      add(0, 1, 1, 32'h102,     1, 32'h104, I+32'h41,0, 10'h42);
      add(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h40);
      add(0, 1, 0, 32'h0,       1, 32'h102, 32'h0,   1, 10'h40);  // fault entry
      add(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h40);
      add(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h40);
      // Out-of-range redirect from STOPPED
      add(0, 1, 1, 32'h1000,    0, 32'h0,   32'h0,   0, 10'h40);
      add(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h0);
      add(0, 1, 0, 32'h0,       1, 32'h1000,32'h0,   1, 10'h0);
      add(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h0);
      // Redirect to 0 resumes
      add(0, 1, 1, 32'h0,       0, 32'h0,   32'h0,   0, 10'h0);
      add(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h0);
      add(0, 1, 0, 32'h0,       1, 32'h0,   I+0,     0, 10'h1);
      add(0, 1, 0, 32'h0,       1, 32'h4,   I+1,     0, 10'h2);
      // Reset mid-stream with full queue
      add(0, 0, 0, 32'h0,       1, 32'h8,   I+2,     0, 10'h3);
      add(0, 0, 0, 32'h0,       1, 32'h8,   I+2,     0, 10'h4);   // full 8,12
      add(1, 0, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h0);
      add(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h0);
      add(0, 1, 0, 32'h0,       1, 32'h0,   I+0,     0, 10'h1);
      add(0, 0, 0, 32'h0,       1, 32'h4,   I+1,     0, 10'h2);   // full 4,8
      // Redirect coinciding with pop on a full queue
      add(0, 1, 1, 32'h200,     1, 32'h4,   I+1,     0, 10'h3);
      add(0, 1, 0, 32'h0,       0, 32'h0,   32'h0,   0, 10'h80);
      add(0, 1, 0, 32'h0,       1, 32'h200, I+32'h80,0, 10'h81);

      foreach (vecs[k]) begin
         @(negedge clock);
         reset          = vecs[k].rst;
         out_ready      = vecs[k].rdy;
         redirect_valid = vecs[k].rv;
         redirect_pc    = vecs[k].rpc;
         #1;
         check($sformatf("v%0d out_valid", k),   {31'h0, out_valid},     {31'h0, vecs[k].ev});
         check($sformatf("v%0d out_pc", k),      out_pc,                 vecs[k].epc);
         check($sformatf("v%0d out_instr", k),   out_instr,              vecs[k].ei);
         check($sformatf("v%0d out_fault", k),   {31'h0, out_fault},     {31'h0, vecs[k].ef});
         check($sformatf("v%0d rom_address", k), {22'h0, rom_address},   {22'h0, vecs[k].ea});
      end

      // Low-bit misaligned redirect: bounded wait for the fault entry,
      // then the output must stay idle.
      @(negedge clock);
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3;
      @(negedge clock);
      redirect_valid = 1'b0;
      #1;
      check("redir3 gap valid", {31'h0, out_valid}, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         @(negedge clock);
         #1;
         found = out_valid;
      end
      check("redir3 fault seen", {31'h0, found}, 32'h1);
      check("redir3 fault flag", {31'h0, out_fault}, 32'h1);
      check("redir3 fault pc", out_pc, 32'h3);
      check("redir3 fault instr", out_instr, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         #1;
         check($sformatf("stopped idle %0d", i), {31'h0, out_valid}, 32'h0);
      end

      // Reset and redirect together: reset wins, fetch restarts at 0.
      @(negedge clock);
      reset          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      @(negedge clock);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check("rst+redir rom", {22'h0, rom_address}, 32'h0);
      check("rst+redir valid", {31'h0, out_valid}, 32'h0);
      @(negedge clock);
      #1;
      check("rst+redir head pc", out_pc, 32'h0);
      check("rst+redir head instr", out_instr, I);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
